// File: rtl/execute_upwards_new_bro_node_mix_array_arbiter.sv
// Round-robin arbiter sharing the dual-port mix_array RAM (port 0 RW, port 1 RO) among NUM_REQ requesters.
// Zero-fills the RAM after reset and on clear_start. Optional stall counter: define MIX_ARB_STALL_CNT_EN.
module execute_upwards_new_bro_node_mix_array_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 5,
   parameter int AddressRange = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear_start,
   output logic                              init_done,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0]                req_we,
   input  logic [NUM_REQ*AddressWidth-1:0]   req_addr,
   input  logic [NUM_REQ*DataWidth-1:0]      req_data,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [NUM_REQ*DataWidth-1:0]      rsp_data,
   output logic [AddressWidth-1:0]           address0,
   output logic                              ce0,
   output logic                              we0,
   output logic [DataWidth-1:0]              d0,
   input  logic [DataWidth-1:0]              q0,
   output logic [AddressWidth-1:0]           address1,
   output logic                              ce1,
   input  logic [DataWidth-1:0]              q1
`ifdef MIX_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                       stall_cnt
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(AddressRange + 1);

   typedef enum logic {CLEAR, RUN} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            rsp0_v_q, rsp0_v_d, rsp1_v_q, rsp1_v_d;
   logic [IW-1:0]   rsp0_req_q, rsp0_req_d, rsp1_req_q, rsp1_req_d;
   logic            g0_v, g1_v;
   logic [IW-1:0]   g0, g1, sel;

   // g0: first valid from rr_ptr; g1: first read after g0 (reads only, port 1 is read-only)
   always_comb begin
      g0_v = 1'b0;
      g0   = '0;
      g1_v = 1'b0;
      g1   = '0;
      sel  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!g0_v && req_valid[sel]) begin
            g0_v = 1'b1;
            g0   = sel;
         end
      end
      for (int k = 1; k < NUM_REQ; k++) begin
         sel = IW'((int'(g0) + k) % NUM_REQ);
         if (g0_v && !g1_v && req_valid[sel] && !req_we[sel]) begin
            g1_v = 1'b1;
            g1   = sel;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      rsp0_v_d   = 1'b0;
      rsp0_req_d = rsp0_req_q;
      rsp1_v_d   = 1'b0;
      rsp1_req_d = rsp1_req_q;
      init_done  = 1'b0;
      req_ready  = '0;
      ce0        = 1'b0;
      we0        = 1'b0;
      address0   = '0;
      d0         = '0;
      ce1        = 1'b0;
      address1   = '0;
      if (!reset) begin
         case (state_q)
            CLEAR: begin
               ce0       = 1'b1;
               we0       = 1'b1;
               address0  = AddressWidth'(clr_cnt_q);
               clr_cnt_d = clr_cnt_q + 1'b1;
               if (clr_cnt_q == CW'(AddressRange - 1)) state_d = RUN;
            end
            RUN: begin
               init_done = 1'b1;
               if (clear_start) begin
                  state_d   = CLEAR;
                  clr_cnt_d = '0;
               end else begin
                  if (g0_v) begin
                     req_ready[g0] = 1'b1;
                     ce0        = 1'b1;
                     we0        = req_we[g0];
                     address0   = req_addr[int'(g0)*AddressWidth +: AddressWidth];
                     d0         = req_data[int'(g0)*DataWidth +: DataWidth];
                     rsp0_v_d   = !req_we[g0];
                     rsp0_req_d = g0;
                     rr_ptr_d   = (g0 == IW'(NUM_REQ - 1)) ? '0 : g0 + 1'b1;
                  end
                  if (g1_v) begin
                     req_ready[g1] = 1'b1;
                     ce1        = 1'b1;
                     address1   = req_addr[int'(g1)*AddressWidth +: AddressWidth];
                     rsp1_v_d   = 1'b1;
                     rsp1_req_d = g1;
                     rr_ptr_d   = (g1 == IW'(NUM_REQ - 1)) ? '0 : g1 + 1'b1;
                  end
               end
            end
            default: state_d = CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= '0;
         rr_ptr_q   <= '0;
         rsp0_v_q   <= 1'b0;
         rsp0_req_q <= '0;
         rsp1_v_q   <= 1'b0;
         rsp1_req_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp0_v_q   <= rsp0_v_d;
         rsp0_req_q <= rsp0_req_d;
         rsp1_v_q   <= rsp1_v_d;
         rsp1_req_q <= rsp1_req_d;
      end
   end

   // Read data arrives one cycle after grant; route it back via the recorded port
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp0_v_q && rsp0_req_q == IW'(i)) begin
               rsp_valid[i]                      = 1'b1;
               rsp_data[i*DataWidth +: DataWidth] = q0;
            end else if (rsp1_v_q && rsp1_req_q == IW'(i)) begin
               rsp_valid[i]                      = 1'b1;
               rsp_data[i*DataWidth +: DataWidth] = q1;
            end
         end
      end
   end

`ifdef MIX_ARB_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (|(req_valid & ~req_ready) && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = reset ? 16'd0 : stall_q;
`endif

endmodule

// File: tb/tb_execute_upwards_new_bro_node_mix_array_arbiter.sv
// Bench for the mix_array arbiter: directed steps plus random traffic against a memory-level reference model.
// Build with MIX_ARB_STALL_CNT_EN defined to also exercise the stall counter.
module tb_execute_upwards_new_bro_node_mix_array_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int AR = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              clear_start;
   logic              init_done;
   logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_data, rsp_data;
   logic [AW-1:0]     address0, address1;
   logic              ce0, we0, ce1;
   logic [DW-1:0]     d0, q0, q1;
`ifdef MIX_ARB_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   execute_upwards_new_bro_node_mix_array_arbiter #(
      .NUM_REQ(N), .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)
   ) dut (
      .clk(clk), .reset(reset), .clear_start(clear_start), .init_done(init_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
      .address1(address1), .ce1(ce1), .q1(q1)
`ifdef MIX_ARB_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // RAM: dual port, 1-cycle read latency, read-first on port 0
   logic [DW-1:0] ram [AR];
   always @(posedge clk) begin
      if (ce1) q1 <= ram[address1];
      if (ce0) begin
         q0 <= ram[address0];
         if (we0) ram[address0] <= d0;
      end
   end

   // reference model state
   int            n_cmp = 0;
   int            n_err = 0;
   int            m_rr, m_clr_idx, eg0, eg1;
   bit            m_clear;
   logic [DW-1:0] gold [AR];
   logic [N-1:0]  exp_rv, exp_ready, accepted;
   logic [DW-1:0] exp_rd [N];
   logic [15:0]   m_stall;
   logic [DW-1:0] s_before;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_data[i*DW +: DW]  = d;
   endtask

   // predict this cycle's grants from the arbitration rules, then compare all outputs
   task automatic settle_check();
      logic [N*DW-1:0] exp_data;
      #2;
      eg0 = -1;
      eg1 = -1;
      if (!m_clear && !clear_start) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (eg0 < 0 && req_valid[i]) eg0 = i;
         end
         if (eg0 >= 0) begin
            for (int k = 1; k < N; k++) begin
               int i;
               i = (eg0 + k) % N;
               if (eg1 < 0 && req_valid[i] && !req_we[i]) eg1 = i;
            end
         end
      end
      exp_ready = '0;
      if (eg0 >= 0) exp_ready[eg0] = 1'b1;
      if (eg1 >= 0) exp_ready[eg1] = 1'b1;
      exp_data = '0;
      for (int i = 0; i < N; i++) if (exp_rv[i]) exp_data[i*DW +: DW] = exp_rd[i];
      chk("init_done", 128'(init_done), 128'(!m_clear));
      chk("req_ready", 128'(req_ready), 128'(exp_ready));
      chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      chk("rsp_data", 128'(rsp_data), 128'(exp_data));
      if (m_clear) begin
         chk("clr_ce0", 128'(ce0), 128'(1'b1));
         chk("clr_we0", 128'(we0), 128'(1'b1));
         chk("clr_addr0", 128'(address0), 128'(m_clr_idx));
         chk("clr_d0", 128'(d0), 128'(0));
         chk("clr_ce1", 128'(ce1), 128'(1'b0));
      end else begin
         chk("ce0", 128'(ce0), 128'(eg0 >= 0));
         if (eg0 >= 0) begin
            chk("we0", 128'(we0), 128'(req_we[eg0]));
            chk("address0", 128'(address0), 128'(req_addr[eg0*AW +: AW]));
            if (req_we[eg0]) chk("d0", 128'(d0), 128'(req_data[eg0*DW +: DW]));
         end
         chk("ce1", 128'(ce1), 128'(eg1 >= 0));
         if (eg1 >= 0) chk("address1", 128'(address1), 128'(req_addr[eg1*AW +: AW]));
      end
`ifdef MIX_ARB_STALL_CNT_EN
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
   endtask

   // clock edge, then update the model: reads see the memory before this cycle's write
   task automatic advance();
      @(posedge clk);
      #1;
      exp_rv = '0;
      if (eg0 >= 0 && !req_we[eg0]) begin
         exp_rv[eg0] = 1'b1;
         exp_rd[eg0] = gold[req_addr[eg0*AW +: AW]];
      end
      if (eg1 >= 0) begin
         exp_rv[eg1] = 1'b1;
         exp_rd[eg1] = gold[req_addr[eg1*AW +: AW]];
      end
      if (eg0 >= 0 && req_we[eg0]) gold[req_addr[eg0*AW +: AW]] = req_data[eg0*DW +: DW];
      if (|(req_valid & ~exp_ready) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (m_clear) begin
         gold[m_clr_idx] = '0;
         m_clr_idx++;
         if (m_clr_idx == AR) m_clear = 1'b0;
      end else if (clear_start) begin
         m_clear   = 1'b1;
         m_clr_idx = 0;
      end
      if (eg1 >= 0) m_rr = (eg1 + 1) % N;
      else if (eg0 >= 0) m_rr = (eg0 + 1) % N;
      accepted    = req_valid & exp_ready;
      req_valid   = req_valid & ~accepted;
      clear_start = 1'b0;
   endtask

   task automatic cycle();
      settle_check();
      advance();
   endtask

   initial begin
      for (int i = 0; i < AR; i++) begin
         ram[i]  = '0;
         gold[i] = '0;
      end
      reset       = 1'b1;
      clear_start = 1'b0;
      req_valid   = N'($urandom);
      req_we      = N'($urandom);
      req_addr    = N*AW'($urandom);
      req_data    = '0;

      // reset: all outputs held at zero
      @(posedge clk);
      #3;
      chk("rst_init_done", 128'(init_done), 128'(0));
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_ce0", 128'(ce0), 128'(0));
      chk("rst_we0", 128'(we0), 128'(0));
      chk("rst_ce1", 128'(ce1), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = '0;
      m_clear   = 1'b1;
      m_clr_idx = 0;
      m_rr      = 0;
      m_stall   = '0;
      exp_rv    = '0;
      eg0       = -1;
      eg1       = -1;

      // zero-fill sweep with random requests that must not be granted
      for (int c = 0; c < AR; c++) begin
         req_valid = N'($urandom);
         req_we    = N'($urandom);
         cycle();
      end
      req_valid = '0;

      // all three read, rr_ptr=0: req0 port 0 and req1 port 1, then req2 alone
      set_req(0, 1'b0, 5'd0, '0);
      set_req(1, 1'b0, 5'd1, '0);
      set_req(2, 1'b0, 5'd2, '0);
      settle_check();
      chk("first_run_init_done", 128'(init_done), 128'(1));
      chk("rr_cycle_a", 128'(req_ready), 128'(3'b011));
      advance();
      settle_check();
      chk("rr_cycle_b", 128'(req_ready), 128'(3'b100));
      chk("rr_b_ce1", 128'(ce1), 128'(0));
      advance();

      // rr_ptr wrapped to 0: write and read of the same address in one cycle, read-first
      set_req(0, 1'b1, 5'd3, 32'h1234);
      set_req(1, 1'b0, 5'd3, '0);
      settle_check();
      chk("same_addr_ready", 128'(req_ready), 128'(3'b011));
      advance();
      settle_check();
      chk("same_addr_rsp_valid", 128'(rsp_valid), 128'(3'b010));
      chk("same_addr_old", 128'(rsp_data[DW +: DW]), 128'(0));
      advance();

      // write then read back through requester 0
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      cycle();
      set_req(0, 1'b0, 5'd5, '0);
      settle_check();
      chk("rd5_ready", 128'(req_ready[0]), 128'(1));
      advance();
      settle_check();
      chk("rd5_rsp_valid", 128'(rsp_valid[0]), 128'(1));
      chk("rd5_rsp_data", 128'(rsp_data[0 +: DW]), 128'(32'hDEADBEEF));
      advance();
      set_req(1, 1'b0, 5'd3, '0);
      cycle();
      settle_check();
      chk("rd3_rsp_data", 128'(rsp_data[DW +: DW]), 128'(32'h1234));
      advance();

      // clear_start with req1 waiting: blocked for the whole sweep, then reads back zero
      set_req(1, 1'b0, 5'd5, '0);
      clear_start = 1'b1;
      for (int c = 0; c < AR + 1; c++) begin
         settle_check();
         chk("clr_blocks_req1", 128'(req_ready[1]), 128'(0));
         advance();
      end
      cycle();
      settle_check();
      chk("after_clr_rsp_valid", 128'(rsp_valid[1]), 128'(1));
      chk("after_clr_rd5", 128'(rsp_data[DW +: DW]), 128'(0));
      advance();

      // random traffic with occasional clears and withdrawals
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 9) < 6)
                  set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         clear_start = ($urandom_range(0, 199) == 0);
         cycle();
      end
      req_valid = '0;
      for (int c = 0; c < AR + 2; c++) cycle();

`ifdef MIX_ARB_STALL_CNT_EN
      // three writers contend: one grant per cycle, so every cycle stalls
      s_before = 32'(m_stall);
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, 1'b1, AW'(i), $urandom);
         cycle();
      end
      settle_check();
      chk("stall_plus10", 128'(stall_cnt), 128'(s_before[15:0] + 16'd10));
      advance();
      for (int c = 0; c < 65600; c++) begin
         for (int i = 0; i < N; i++) if (!req_valid[i]) set_req(i, 1'b1, AW'(i), $urandom);
         cycle();
      end
      settle_check();
      chk("stall_saturated", 128'(stall_cnt), 128'(16'hFFFF));
      advance();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
